// File: rtl/key_step_pulse_gen.sv
// Key event generator: press/release pulses, long-press level and auto-repeat, with press and
// repeat events forwarded as single-step requests over a req/ack handshake.
module key_step_pulse_gen #(
    parameter int unsigned LONG_CYCLES   = 40,
    parameter int unsigned REPEAT_CYCLES = 10,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DROP_W        = 4
) (
    input  logic              BJ_clk,
    input  logic              rst,
    input  logic              button_level,
    input  logic              step_ack,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              long_press,
    output logic              step_req,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StHeld    = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]  LongLast   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CntOne     = CNT_W'(1);
    localparam logic [DROP_W-1:0] DropOne    = DROP_W'(1);
    localparam logic [DROP_W-1:0] DropMax    = '1;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              r_req;
    logic [DROP_W-1:0] r_drop;
    logic              w_event;

    // A releasing edge never produces an event, so every event needs the key still down.
    always_comb begin
        w_event = 1'b0;
        case (r_state)
            StIdle:    w_event = button_level;
            StPressed: w_event = button_level && (r_cnt == LongLast);
            StHeld:    w_event = button_level && (r_cnt == RepeatLast);
            default:   w_event = 1'b0;
        endcase
    end

    always_ff @(posedge BJ_clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_req     <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (button_level) begin
                        r_state <= StPressed;
                        r_press <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                StPressed: begin
                    if (!button_level) begin
                        r_state   <= StIdle;
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                    end else if (r_cnt == LongLast) begin
                        r_state <= StHeld;
                        r_long  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                StHeld: begin
                    if (!button_level) begin
                        r_state   <= StIdle;
                        r_release <= 1'b1;
                        r_long    <= 1'b0;
                        r_cnt     <= '0;
                    end else if (r_cnt == RepeatLast) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_long  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase

            // An ack on the event edge frees the slot, so the new event re-arms step_req.
            if (w_event) begin
                if (!r_req || step_ack) begin
                    r_req <= 1'b1;
                end else if (r_drop != DropMax) begin
                    r_drop <= r_drop + DropOne;
                end
            end else if (r_req && step_ack) begin
                r_req <= 1'b0;
            end
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_press    = r_long;
    assign step_req      = r_req;
    assign drop_cnt      = r_drop;
    assign state         = r_state;

endmodule

// File: tb/tb_key_step_pulse_gen.sv
// Scoreboard bench for key_step_pulse_gen: stimulus queues expected events with edge indices,
// a negedge monitor pops and compares every observed event.
module tb_key_step_pulse_gen;

    localparam int unsigned LONG = 8;
    localparam int unsigned REP  = 3;
    localparam int unsigned DW   = 4;

    localparam int KPress   = 0;
    localparam int KReq     = 1;
    localparam int KLongOn  = 2;
    localparam int KLongOff = 3;
    localparam int KRelease = 4;

    logic          BJ_clk = 1'b0;
    logic          rst = 1'b0;
    logic          button_level = 1'b0;
    logic          step_ack = 1'b0;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_press;
    logic          step_req;
    logic [DW-1:0] drop_cnt;
    logic [1:0]    state;

    key_step_pulse_gen #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP),
        .CNT_W        (16),
        .DROP_W       (DW)
    ) dut (
        .BJ_clk       (BJ_clk),
        .rst          (rst),
        .button_level (button_level),
        .step_ack     (step_ack),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .step_req     (step_req),
        .drop_cnt     (drop_cnt),
        .state        (state)
    );

    always #5 BJ_clk = ~BJ_clk;

    int edge_cnt = 0;
    always @(posedge BJ_clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   ack_delay = 0;
    int   ack_hi = 0;
    logic mon_p_req = 1'b0;
    logic mon_p_long = 1'b0;

    function automatic string kname(int k);
        case (k)
            KPress:   return "press";
            KReq:     return "req_rise";
            KLongOn:  return "long_rise";
            KLongOff: return "long_fall";
            default:  return "release";
        endcase
    endfunction

    task automatic expect_ev(int k, int e);
        exp_q.push_back('{kind: k, at: e});
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic observe(int k);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got %s at edge %0d, required no event",
                     kname(k), edge_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.at == edge_cnt) n_pass++;
            else $display("FAIL sb_event: got %s at edge %0d, required %s at edge %0d",
                          kname(k), edge_cnt, kname(e.kind), e.at);
        end
    endtask

    // Monitor: one observation per event kind, in a fixed order within a cycle.
    initial begin
        forever begin
            @(negedge BJ_clk);
            if (rst) begin
                if (press_pulse) observe(KPress);
                if (step_req && !mon_p_req) observe(KReq);
                if (long_press && !mon_p_long) observe(KLongOn);
                if (!long_press && mon_p_long) observe(KLongOff);
                if (release_pulse) observe(KRelease);
            end
            mon_p_req  = step_req;
            mon_p_long = long_press;
        end
    end

    // Auto-ack responder: acks after step_req has been seen high ack_delay times; 0 = manual.
    initial begin
        forever begin
            @(negedge BJ_clk);
            if (ack_delay != 0) begin
                if (step_req && !step_ack) begin
                    ack_hi++;
                    if (ack_hi >= ack_delay) begin
                        step_ack = 1'b1;
                        ack_hi   = 0;
                    end
                end else begin
                    step_ack = 1'b0;
                    ack_hi   = 0;
                end
            end
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_press"}, int'(press_pulse), 0);
        check({tag, "_release"}, int'(release_pulse), 0);
        check({tag, "_long"}, int'(long_press), 0);
        check({tag, "_req"}, int'(step_req), 0);
        check({tag, "_drop"}, int'(drop_cnt), 0);
        check({tag, "_state"}, int'(state), 0);
    endtask

    initial begin
        int b;

        repeat (2) @(negedge BJ_clk);
        check_all_zero("reset");
        @(negedge BJ_clk);
        rst = 1'b1;
        repeat (2) @(negedge BJ_clk);

        // Short press, ack two cycles after the request
        ack_delay = 2;
        @(negedge BJ_clk);
        b = edge_cnt + 1;
        button_level = 1'b1;
        expect_ev(KPress, b);
        expect_ev(KReq, b);
        expect_ev(KRelease, b + 5);
        @(negedge BJ_clk);
        check("short_state_pressed", int'(state), 1);
        @(negedge BJ_clk);
        check("short_req_held", int'(step_req), 1);
        @(negedge BJ_clk);
        check("short_req_acked", int'(step_req), 0);
        repeat (2) @(negedge BJ_clk);
        button_level = 1'b0;
        repeat (3) @(negedge BJ_clk);
        check("short_drop", int'(drop_cnt), 0);

        // Long press with auto-repeat, ack one cycle after each request
        ack_delay = 1;
        @(negedge BJ_clk);
        b = edge_cnt + 1;
        button_level = 1'b1;
        expect_ev(KPress, b);
        expect_ev(KReq, b);
        expect_ev(KReq, b + 8);
        expect_ev(KLongOn, b + 8);
        expect_ev(KReq, b + 11);
        expect_ev(KReq, b + 14);
        expect_ev(KReq, b + 17);
        expect_ev(KLongOff, b + 20);
        expect_ev(KRelease, b + 20);
        repeat (10) @(negedge BJ_clk);
        check("long_state_held", int'(state), 2);
        repeat (10) @(negedge BJ_clk);
        button_level = 1'b0;
        repeat (3) @(negedge BJ_clk);
        check("long_drop", int'(drop_cnt), 0);

        // Repeat event on the same edge as an ack
        ack_delay = 0;
        step_ack  = 1'b0;
        @(negedge BJ_clk);
        b = edge_cnt + 1;
        button_level = 1'b1;
        expect_ev(KPress, b);
        expect_ev(KReq, b);
        expect_ev(KReq, b + 8);
        expect_ev(KLongOn, b + 8);
        expect_ev(KLongOff, b + 12);
        expect_ev(KRelease, b + 12);
        @(negedge BJ_clk);
        step_ack = 1'b1;
        @(negedge BJ_clk);
        step_ack = 1'b0;
        repeat (9) @(negedge BJ_clk);
        step_ack = 1'b1;
        @(negedge BJ_clk);
        step_ack = 1'b0;
        check("simul_req_kept", int'(step_req), 1);
        check("simul_drop_unchanged", int'(drop_cnt), 0);
        button_level = 1'b0;
        @(negedge BJ_clk);
        step_ack = 1'b1;
        @(negedge BJ_clk);
        step_ack = 1'b0;
        check("simul_req_cleared", int'(step_req), 0);
        repeat (2) @(negedge BJ_clk);

        // Key released exactly on the long-press edge
        ack_delay = 1;
        @(negedge BJ_clk);
        b = edge_cnt + 1;
        button_level = 1'b1;
        expect_ev(KPress, b);
        expect_ev(KReq, b);
        expect_ev(KRelease, b + 8);
        repeat (8) @(negedge BJ_clk);
        button_level = 1'b0;
        @(negedge BJ_clk);
        check("rel8_long_low", int'(long_press), 0);
        check("rel8_state_idle", int'(state), 0);
        check("rel8_no_req", int'(step_req), 0);
        repeat (2) @(negedge BJ_clk);

        // Drop counting with no ack at all
        ack_delay = 0;
        step_ack  = 1'b0;
        @(negedge BJ_clk);
        b = edge_cnt + 1;
        button_level = 1'b1;
        expect_ev(KPress, b);
        expect_ev(KReq, b);
        expect_ev(KLongOn, b + 8);
        expect_ev(KLongOff, b + 20);
        expect_ev(KRelease, b + 20);
        repeat (20) @(negedge BJ_clk);
        button_level = 1'b0;
        repeat (2) @(negedge BJ_clk);
        check("drop_four", int'(drop_cnt), 4);
        check("drop_req_stuck", int'(step_req), 1);

        @(negedge BJ_clk);
        b = edge_cnt + 1;
        button_level = 1'b1;
        expect_ev(KPress, b);
        expect_ev(KLongOn, b + 8);
        expect_ev(KLongOff, b + 60);
        expect_ev(KRelease, b + 60);
        repeat (60) @(negedge BJ_clk);
        button_level = 1'b0;
        repeat (2) @(negedge BJ_clk);
        check("drop_saturated", int'(drop_cnt), 15);

        // Asynchronous reset in the middle of HELD, key kept down through deassertion
        @(negedge BJ_clk);
        b = edge_cnt + 1;
        button_level = 1'b1;
        expect_ev(KPress, b);
        expect_ev(KLongOn, b + 8);
        repeat (11) @(negedge BJ_clk);
        check("prereset_long", int'(long_press), 1);
        check("prereset_req", int'(step_req), 1);
        #2 rst = 1'b0;
        #1 check_all_zero("midheld_reset");
        repeat (2) @(negedge BJ_clk);
        ack_delay = 1;
        @(negedge BJ_clk);
        b = edge_cnt + 1;
        rst = 1'b1;
        expect_ev(KPress, b);
        expect_ev(KReq, b);
        expect_ev(KRelease, b + 3);
        repeat (3) @(negedge BJ_clk);
        button_level = 1'b0;
        repeat (4) @(negedge BJ_clk);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
